spi_master_gen2: RTL and testbench

SPI_MASTER_GEN2 -- requirements
Module: spi_master_gen2

---
 rtl/spi_master_gen2.sv | 176 +++++++++++++++++
 tb/tb_spi_master_gen2.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_gen2.sv
// spi_master_gen2 -- SPI master supporting modes 0-3 with NUM_CS active-low
// chip selects. Frames are MSB-first by default; defining SPI_LSB_FIRST_EN
// adds a lsb_first input selecting LSB-first framing per transfer.
module spi_master_gen2 #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int NUM_CS  = 2,
    localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
`ifdef SPI_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t              state_q;
    logic [DIV_W-1:0]    div_q;
    logic [EDGE_W-1:0]   edge_q;
    logic [DATA_W-1:0]   tx_sr_q;
    logic [DATA_W-1:0]   rx_sr_q;
    logic [DATA_W-1:0]   rx_data_q;
    logic [NUM_CS-1:0]   cs_n_q;
    logic                cpha_q;
    logic                lsb_q;
    logic                sclk_q;
    logic                mosi_q;
    logic                busy_q;
    logic                done_q;

    logic                lsb_in;
    logic                accept;
    logic                div_end;
    logic                leading;
    logic                last_edge;
    logic [DATA_W-1:0]   tx_load;
    logic [DATA_W-1:0]   rx_word;

    function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            r[i] = v[DATA_W-1-i];
        end
        return r;
    endfunction

`ifdef SPI_LSB_FIRST_EN
    assign lsb_in = lsb_first;
`else
    assign lsb_in = 1'b0;
`endif

    // Acceptance, edge classification and bit-order mapping.
    // LSB-first frames are reversed on load and on completion so the shift
    // datapath itself only ever runs MSB-first.
    always_comb begin
        accept    = (state_q == IDLE) && start && (int'(cs_sel) < NUM_CS);
        div_end   = (div_q == DIV_LAST);
        leading   = ~edge_q[0];
        last_edge = (edge_q == EDGE_LAST);
        tx_load   = lsb_in ? bit_rev(tx_data) : tx_data;
        rx_word   = lsb_q ? bit_rev(rx_sr_q) : rx_sr_q;
    end

    // Transfer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            edge_q    <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            cs_n_q    <= '1;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    sclk_q <= cpol;
                    mosi_q <= 1'b0;
                    div_q  <= '0;
                    if (accept) begin
                        state_q <= SETUP;
                        busy_q  <= 1'b1;
                        cs_n_q  <= ~(NUM_CS'(1) << cs_sel);
                        cpha_q  <= cpha;
                        lsb_q   <= lsb_in;
                        edge_q  <= '0;
                        rx_sr_q <= '0;
                        if (cpha) begin
                            // First leading edge presents the MSB.
                            tx_sr_q <= tx_load;
                        end else begin
                            mosi_q  <= tx_load[DATA_W-1];
                            tx_sr_q <= {tx_load[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                SETUP: begin
                    div_q <= div_end ? '0 : div_q + DIV_W'(1);
                    if (div_end) begin
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    div_q <= div_end ? '0 : div_q + DIV_W'(1);
                    if (div_end) begin
                        sclk_q <= ~sclk_q;
                        edge_q <= edge_q + EDGE_W'(1);
                        if (leading == cpha_q) begin
                            // Shift edge; mode 0/2 skips the final trailing edge.
                            if (cpha_q || !last_edge) begin
                                mosi_q  <= tx_sr_q[DATA_W-1];
                                tx_sr_q <= {tx_sr_q[DATA_W-2:0], 1'b0};
                            end
                        end else begin
                            rx_sr_q <= {rx_sr_q[DATA_W-2:0], miso};
                        end
                        if (last_edge) begin
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    div_q <= div_end ? '0 : div_q + DIV_W'(1);
                    if (div_end) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        cs_n_q    <= '1;
                        mosi_q    <= 1'b0;
                        sclk_q    <= cpol;
                        rx_data_q <= rx_word;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rx_data = rx_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master_gen2.sv
// tb_spi_master_gen2 -- self-checking bench for spi_master_gen2 (default
// MSB-first build). A behavioural SPI slave inside the bench shifts out a
// word on miso and captures mosi according to the SPI mode rules. NUM_CS is
// 3 so that an out-of-range select (3) is representable on cs_sel.
module tb_spi_master_gen2;

    localparam int DW  = 8;
    localparam int DIV = 4;
    localparam int NCS = 3;
    localparam int LAT = 1 + (2 * DW + 2) * DIV;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [DW-1:0]  tx_data;
    logic [1:0]     cs_sel;
    logic           cpol;
    logic           cpha;
    logic [DW-1:0]  rx_data;
    logic           busy;
    logic           done;
    logic           sclk;
    logic           mosi;
    logic           miso;
    logic [NCS-1:0] cs_n;

    int vectors = 0;
    int errors  = 0;
    int cycle_no = 0;
    int last_done_cycle = -1;
    logic [DW-1:0] exp_rx = '0;

    spi_master_gen2 #(
        .DATA_W (DW),
        .CLK_DIV(DIV),
        .NUM_CS (NCS)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .tx_data(tx_data),
        .cs_sel (cs_sel),
        .cpol   (cpol),
        .cpha   (cpha),
        .rx_data(rx_data),
        .busy   (busy),
        .done   (done),
        .sclk   (sclk),
        .mosi   (mosi),
        .miso   (miso),
        .cs_n   (cs_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_no <= cycle_no + 1;

    // One transfer seen from the slave side. Cycle 0 is the cycle in which
    // start is presented; cycle c is observed at the falling edge.
    //   chained    : start was already driven by the previous call
    //   rst_at     : cycle at which reset is pulsed (-1 = none)
    //   poke_at    : cycle at which stray starts are driven while busy (-1 = none)
    //   chain_next : hold start high with next_tx through the done cycle
    task automatic xfer(input string name, input logic [DW-1:0] tx, input logic [DW-1:0] sw,
                        input int sel, input logic pol, input logic pha,
                        input bit chained, input int rst_at, input int poke_at,
                        input bit chain_next, input logic [DW-1:0] next_tx);
        logic [DW-1:0]  cap;
        logic [NCS-1:0] cs_exp;
        logic           prev_sclk;
        logic           lead;
        logic           exp_busy;
        bit             was_reset;
        int ncap, nsent, nedge, first_edge, last_edge;
        int done_at, ndone, bad_cs, bad_busy, bad_rx, bad_lvl, gap;
        cap = '0; ncap = 0; nsent = 0; nedge = 0; first_edge = -1; last_edge = -1;
        done_at = -1; ndone = 0; bad_cs = 0; bad_busy = 0; bad_rx = 0; bad_lvl = 0; gap = -1;
        was_reset = 0;
        if (!chained) begin
            @(negedge clk);
            start = 1'b1; tx_data = tx; cs_sel = 2'(sel); cpol = pol; cpha = pha;
        end
        prev_sclk = pol;
        for (int c = 1; c <= LAT + 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                // Scramble inputs: the running transfer must not notice.
                start = 1'b0; tx_data = DW'($urandom); cs_sel = 2'($urandom_range(0, 2));
                cpol = ~pol; cpha = ~pha;
                if (!pha) begin
                    miso = sw[DW-1]; nsent = 1;
                    vectors++;
                    if (mosi !== tx[DW-1]) begin
                        errors++;
                        $display("FAIL %s first_mosi: got %b want %b", name, mosi, tx[DW-1]);
                    end
                end else begin
                    miso = 1'($urandom);
                end
            end
            if (c == LAT - 4) begin
                cpol = pol; cpha = pha;
            end
            if (chain_next && c == LAT - 3) begin
                start = 1'b1; tx_data = next_tx; cs_sel = 2'(sel); cpol = pol; cpha = pha;
            end
            if (poke_at >= 0 && c == poke_at) start = 1'b1;
            if (poke_at >= 0 && c == poke_at + 1) cs_sel = 2'd3;
            if (poke_at >= 0 && c == poke_at + 2) start = 1'b0;
            if (rst_at >= 0 && c == rst_at) rst = 1'b1;
            if (rst_at >= 0 && c == rst_at + 1) begin
                rst = 1'b0;
                was_reset = 1;
                exp_rx = '0;
                vectors++;
                if ({cs_n, busy, sclk, mosi, done} !== {{NCS{1'b1}}, 4'b0000}) begin
                    errors++;
                    $display("FAIL %s post_reset {cs_n,busy,sclk,mosi,done}: got %b want %b",
                             name, {cs_n, busy, sclk, mosi, done}, {{NCS{1'b1}}, 4'b0000});
                end
                vectors++;
                if (rx_data !== '0) begin
                    errors++;
                    $display("FAIL %s post_reset rx_data: got %h want 00", name, rx_data);
                end
            end

            exp_busy = (c < LAT) && !was_reset;
            cs_exp   = exp_busy ? ~(NCS'(1) << sel) : '1;
            if (busy !== exp_busy) bad_busy++;
            if (cs_n !== cs_exp) bad_cs++;
            if (done === 1'b1) begin
                ndone++;
                done_at = c;
                if (last_done_cycle >= 0) gap = cycle_no - last_done_cycle;
                last_done_cycle = cycle_no;
            end
            if (c == LAT && !was_reset) begin
                vectors++;
                if (rx_data !== sw) begin
                    errors++;
                    $display("FAIL %s rx_data: got %h want %h", name, rx_data, sw);
                end
                exp_rx = sw;
            end else if (rx_data !== exp_rx) begin
                bad_rx++;
            end
            if (exp_busy && (c <= DIV || c >= LAT - DIV) && sclk !== pol) bad_lvl++;
            if (!exp_busy && !chained && c >= LAT && mosi !== 1'b0) bad_lvl++;

            if (exp_busy && sclk !== prev_sclk) begin
                nedge++;
                if (first_edge < 0) first_edge = c;
                last_edge = c;
                lead = (sclk !== pol);
                if (lead == !pha) begin
                    cap = {cap[DW-2:0], mosi};
                    ncap++;
                end else if (nsent < DW) begin
                    miso = sw[DW-1-nsent];
                    nsent++;
                end
            end
            prev_sclk = sclk;
            if (chain_next && c == LAT) break;
        end

        vectors++;
        if (bad_busy !== 0) begin
            errors++;
            $display("FAIL %s busy_cycles_wrong: got %0d want 0", name, bad_busy);
        end
        vectors++;
        if (bad_cs !== 0) begin
            errors++;
            $display("FAIL %s cs_n_cycles_wrong: got %0d want 0", name, bad_cs);
        end
        vectors++;
        if (bad_rx !== 0) begin
            errors++;
            $display("FAIL %s rx_hold_cycles_wrong: got %0d want 0", name, bad_rx);
        end
        if (was_reset) begin
            vectors++;
            if (ndone !== 0) begin
                errors++;
                $display("FAIL %s done_after_reset: got %0d want 0", name, ndone);
            end
        end else begin
            vectors++;
            if (ndone !== 1 || done_at !== LAT) begin
                errors++;
                $display("FAIL %s done: got %0d pulses at %0d want 1 at %0d", name, ndone, done_at, LAT);
            end
            vectors++;
            if (cap !== tx || ncap !== DW) begin
                errors++;
                $display("FAIL %s mosi_word: got %h (%0d bits) want %h", name, cap, ncap, tx);
            end
            vectors++;
            if (nedge !== 2 * DW || first_edge !== 1 + 2 * DIV || last_edge !== 1 + (2 * DW + 1) * DIV) begin
                errors++;
                $display("FAIL %s sclk_edges: got %0d first %0d last %0d want %0d first %0d last %0d",
                         name, nedge, first_edge, last_edge, 2 * DW, 1 + 2 * DIV, 1 + (2 * DW + 1) * DIV);
            end
            vectors++;
            if (bad_lvl !== 0) begin
                errors++;
                $display("FAIL %s idle_level_cycles_wrong: got %0d want 0", name, bad_lvl);
            end
            if (chained) begin
                vectors++;
                if (gap !== LAT) begin
                    errors++;
                    $display("FAIL %s done_spacing: got %0d want %0d", name, gap, LAT);
                end
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({cs_n, busy, done, sclk, mosi} !== {{NCS{1'b1}}, 4'b0000}) begin
            errors++;
            $display("FAIL reset outputs: got %b want %b", {cs_n, busy, done, sclk, mosi}, {{NCS{1'b1}}, 4'b0000});
        end
        vectors++;
        if (rx_data !== '0) begin
            errors++;
            $display("FAIL reset rx_data: got %h want 00", rx_data);
        end
        rst = 1'b0;
        cpol = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (sclk !== 1'b1 || mosi !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_cpol1 {sclk,mosi,busy}: got %b want 100", {sclk, mosi, busy});
        end
        cpol = 1'b0;
        @(negedge clk);
        exp_rx = '0;
    endtask

    task automatic test_mode0_basic();
        xfer("mode0_a5", 8'hA5, 8'h3C, 1, 1'b0, 1'b0, 0, -1, -1, 0, '0);
    endtask

    task automatic test_modes();
        xfer("mode1", 8'h96, 8'h69, 0, 1'b0, 1'b1, 0, -1, -1, 0, '0);
        xfer("mode2", 8'h96, 8'h69, 2, 1'b1, 1'b0, 0, -1, -1, 0, '0);
        xfer("mode3", 8'h96, 8'h69, 1, 1'b1, 1'b1, 0, -1, -1, 0, '0);
    endtask

    task automatic test_random();
        logic [1:0] m;
        for (int i = 0; i < 4; i++) begin
            m = 2'($urandom);
            xfer("random", DW'($urandom), DW'($urandom), int'($urandom_range(0, NCS - 1)),
                 m[1], m[0], 0, -1, -1, 0, '0);
        end
    endtask

    task automatic test_ignored_starts();
        int bad;
        xfer("start_while_busy", 8'h5A, 8'hC3, 0, 1'b0, 1'b0, 0, -1, 10, 0, '0);
        bad = 0;
        @(negedge clk);
        start = 1'b1; cs_sel = 2'd3; tx_data = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (busy !== 1'b0 || done !== 1'b0 || cs_n !== '1 || rx_data !== exp_rx) bad++;
            @(negedge clk);
        end
        vectors++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bad_cs_sel_ignored: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        xfer("reset_mid", 8'hE7, 8'h81, 1, 1'b0, 1'b0, 0, 30, -1, 0, '0);
    endtask

    task automatic test_back_to_back();
        xfer("b2b_first", 8'h11, 8'h42, 2, 1'b0, 1'b0, 0, -1, -1, 1, 8'h22);
        xfer("b2b_second", 8'h22, 8'h99, 2, 1'b0, 1'b0, 1, -1, -1, 0, '0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tx_data = '0; cs_sel = '0;
        cpol = 1'b0; cpha = 1'b0; miso = 1'b0;
        test_reset();
        test_mode0_basic();
        test_modes();
        test_random();
        test_ignored_starts();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
